// File: rtl/elc3_mem_ctrl.sv
// eLC-3 memory/I-O controller: wait-stated RAM access with a one-cycle ready pulse.
// Define ELC3_MMIO_EN to map LEDR/SW/LEDG registers at IO_BASE and above.
module elc3_mem_ctrl #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned IO_BASE     = 16'hFE00
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic [ADDR_W-1:0] MAR,
  input  logic [DATA_W-1:0] MDR_out,
  output logic [DATA_W-1:0] MDR_in,
  output logic              R,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  input  logic [17:0]       SW,
  output logic [17:0]       LEDR,
  output logic [8:0]        LEDG
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              rw_q;
  logic              io_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mdr_q;
  logic              r_q;
  logic              ce_q;
  logic              we_q;
  logic              req_io;
  logic [DATA_W-1:0] io_rdata;

`ifdef ELC3_MMIO_EN
  localparam logic [ADDR_W-1:0] IoBase = ADDR_W'(IO_BASE);

  logic [17:0] ledr_q;
  logic [8:0]  ledg_q;

  assign req_io = (MAR >= IoBase);

  always_comb begin
    io_rdata = '0;
    if (addr_q == IoBase) begin
      io_rdata = DATA_W'(ledr_q);
    end else if (addr_q == IoBase + ADDR_W'(1)) begin
      io_rdata = DATA_W'(SW);
    end else if (addr_q == IoBase + ADDR_W'(2)) begin
      io_rdata = DATA_W'(ledg_q);
    end
  end

  // LED registers load at the edge that closes the single I/O ACCESS cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ledr_q <= '0;
      ledg_q <= '0;
    end else if (state_q == StAccess && io_q && rw_q) begin
      if (addr_q == IoBase) begin
        ledr_q <= 18'(wdata_q);
      end else if (addr_q == IoBase + ADDR_W'(2)) begin
        ledg_q <= 9'(wdata_q);
      end
    end
  end

  assign LEDR = ledr_q;
  assign LEDG = ledg_q;
`else
  logic unused_sw;

  assign unused_sw = ^SW;
  assign req_io    = 1'b0;
  assign io_rdata  = '0;
  assign LEDR      = '0;
  assign LEDG      = '0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
      r_q     <= 1'b0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          r_q <= 1'b0;
          if (MIO_EN) begin
            addr_q  <= MAR;
            wdata_q <= MDR_out;
            rw_q    <= R_W;
            io_q    <= req_io;
            cnt_q   <= 4'(WAIT_STATES);
            ce_q    <= !req_io;
            we_q    <= R_W && !req_io;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (io_q || cnt_q == 4'd0) begin
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            r_q     <= 1'b1;
            state_q <= StDone;
            if (!rw_q) begin
              mdr_q <= io_q ? io_rdata : mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          r_q     <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign MDR_in    = mdr_q;
  assign R         = r_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ce    = ce_q;
  assign mem_we    = we_q;

endmodule

// File: tb/tb_elc3_mem_ctrl.sv
// Scoreboard bench for elc3_mem_ctrl with a registered-read RAM model (WAIT_STATES=2).
// Covers the MMIO decode when ELC3_MMIO_EN is defined, plain RAM mapping otherwise.
module tb_elc3_mem_ctrl;

  localparam int unsigned Wait = 2;
`ifdef ELC3_MMIO_EN
  localparam bit Mmio = 1'b1;
`else
  localparam bit Mmio = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] MAR;
  logic [15:0] MDR_out;
  logic [15:0] MDR_in;
  logic        R;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ce;
  logic        mem_we;
  logic [17:0] SW;
  logic [17:0] LEDR;
  logic [8:0]  LEDG;

  always #5 Clk = ~Clk;

  elc3_mem_ctrl #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .WAIT_STATES(Wait),
    .IO_BASE    (16'hFE00)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .MIO_EN   (MIO_EN),
    .R_W      (R_W),
    .MAR      (MAR),
    .MDR_out  (MDR_out),
    .MDR_in   (MDR_in),
    .R        (R),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .SW       (SW),
    .LEDR     (LEDR),
    .LEDG     (LEDG)
  );

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a == 16'h3000) ? 16'hBEEF : (a ^ 16'hA5C3);
  endfunction

  // Synchronous-read RAM: data registered on every enabled edge.
  logic [15:0] ram [0:65535];
  bit          ram_ready = 1'b0;
  always @(posedge Clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_word(16'(i));
      ram_ready <= 1'b1;
    end else if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    bit          io;
    logic [15:0] addr;
    logic [15:0] data;
    logic [17:0] ledr;
    logic [8:0]  ledg;
    logic [15:0] mdr;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] wr_mem [logic [15:0]];
  logic [17:0] m_ledr = '0;
  logic [8:0]  m_ledg = '0;
  logic [15:0] m_mdr  = '0;

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (Mmio && a >= 16'hFE00) begin
      case (a)
        16'hFE00: return 16'(m_ledr);
        16'hFE01: return 16'(SW);
        16'hFE02: return 16'(m_ledg);
        default:  return 16'h0000;
      endcase
    end
    return wr_mem.exists(a) ? wr_mem[a] : init_word(a);
  endfunction

  // hold keeps MIO_EN high; the next call must then use b2b to chain from the DONE cycle.
  task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                        input bit hold, input bit b2b);
    exp_t e;
    int   cyc;
    int   ce_cnt;
    bit   seen_ce;
    bit   got_r;
    if (b2b) begin
      R_W = wr; MAR = addr; MDR_out = data; MIO_EN = 1'b1;
      @(posedge Clk); #1;
      check_eq("gap_r", R, 0);
      check_eq("gap_ce", mem_ce, 0);
    end else begin
      @(negedge Clk);
      R_W = wr; MAR = addr; MDR_out = data; MIO_EN = 1'b1;
    end
    e.wr = wr; e.addr = addr; e.data = data;
    e.io = Mmio && addr >= 16'hFE00;
    if (wr) begin
      if (e.io) begin
        if (addr == 16'hFE00) m_ledr = 18'(data);
        else if (addr == 16'hFE02) m_ledg = 9'(data);
      end else begin
        wr_mem[addr] = data;
      end
    end else begin
      m_mdr = model_rd(addr);
    end
    e.ledr = m_ledr; e.ledg = m_ledg; e.mdr = m_mdr;
    sb.push_back(e);

    @(posedge Clk);
    cyc = 0; ce_cnt = 0; seen_ce = 0; got_r = 0;
    while (cyc < 30 && !got_r) begin
      #1;
      cyc++;
      if (cyc == 1 && !hold) MIO_EN = 1'b0;
      if (R) begin
        got_r = 1;
      end else begin
        if (mem_ce) begin
          ce_cnt++;
          if (!seen_ce) begin
            seen_ce = 1;
            check_eq("ram_addr", mem_addr, sb[0].addr);
            check_eq("ram_we", mem_we, sb[0].wr);
            if (sb[0].wr) check_eq("ram_wdata", mem_wdata, sb[0].data);
          end
        end
        @(posedge Clk);
      end
    end
    e = sb.pop_front();
    check_eq("latency", cyc, e.io ? 2 : Wait + 2);
    check_eq("ce_cycles", ce_cnt, e.io ? 0 : Wait + 1);
    check_eq("mdr_in", MDR_in, e.mdr);
    check_eq("ledr", LEDR, e.ledr);
    check_eq("ledg", LEDG, e.ledg);
    if (!hold) begin
      @(posedge Clk); #1;
      check_eq("r_one_cycle", R, 0);
    end
  endtask

  initial begin
    int r_seen;
    Reset = 1'b1; MIO_EN = 1'b0; R_W = 1'b0; MAR = '0; MDR_out = '0; SW = 18'h155;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    check_eq("rst_r", R, 0);
    check_eq("rst_ce", mem_ce, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_ledr", LEDR, 0);
    check_eq("rst_ledg", LEDG, 0);
    check_eq("rst_mdr", MDR_in, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);

    access(1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0);
    check_eq("beef", MDR_in, 16'hBEEF);
    access(1'b1, 16'h0010, 16'h1111, 1'b0, 1'b0);
    access(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);

    // Two held writes, then read both back.
    access(1'b1, 16'h0020, 16'hA0A0, 1'b1, 1'b0);
    access(1'b1, 16'h0021, 16'h5B5B, 1'b0, 1'b1);
    access(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);
    access(1'b0, 16'h0021, 16'h0000, 1'b0, 1'b0);

    // FE00 is an LED register in the MMIO build and plain RAM otherwise.
    access(1'b1, 16'hFE00, Mmio ? 16'h002A : 16'h1234, 1'b0, 1'b0);
    access(1'b0, 16'hFE01, 16'h0000, 1'b0, 1'b0);
    access(1'b0, 16'hFE00, 16'h0000, 1'b0, 1'b0);
    access(1'b1, 16'hFE02, 16'hFFFF, 1'b0, 1'b0);
    access(1'b1, 16'hFE01, 16'h7777, 1'b0, 1'b0);
    access(1'b0, 16'hFE02, 16'h0000, 1'b0, 1'b0);
    access(1'b0, 16'hFE05, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      access(1'($urandom_range(0, 1)), 16'h0040 + 16'($urandom_range(0, 3)),
             16'($urandom), 1'b0, 1'b0);
    end

    // Reset during the second ACCESS cycle of a RAM write.
    @(negedge Clk);
    R_W = 1'b1; MAR = 16'h4000; MDR_out = 16'hCAFE; MIO_EN = 1'b1;
    wr_mem[16'h4000] = 16'hCAFE;
    @(posedge Clk); #1;
    MIO_EN = 1'b0;
    check_eq("rw_ce", mem_ce, 1);
    check_eq("rw_we", mem_we, 1);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    m_mdr = '0; m_ledr = '0; m_ledg = '0;
    check_eq("abort_r", R, 0);
    check_eq("abort_ce", mem_ce, 0);
    check_eq("abort_we", mem_we, 0);
    check_eq("abort_mdr", MDR_in, 0);
    r_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      if (R) r_seen++;
    end
    check_eq("abort_no_r", r_seen, 0);
    access(1'b0, 16'h4000, 16'h0000, 1'b0, 1'b0);
    access(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
